// File: rtl/cu_multicycle.sv
// Multi-cycle RV32I control unit: instruction register, fetch/decode/exec/mem/wb sequencing.
// The optional macro CU_ILLEGAL_TRAP_EN routes unsupported opcodes to a sticky TRAP state.
//
// state  | meaning
// FETCH  | imem_req held until imem_ready, IR loaded on ready
// DECODE | one cycle for fields/imm/selects to settle from IR
// EXEC   | ALU operation; branches resolve and update PC here
// MEM    | dmem_req held until dmem_ready; stores retire here
// WB     | register write-back and PC update
// TRAP   | illegal opcode, held until reset
module cu_multicycle #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic [2:0]       dmem_funct3,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             pc_lsb_clr,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [2:0]       alu_func3,
  output logic             alu_subsra,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      ir;
  logic [CNT_W-1:0] retired_q;
  logic [6:0]       opcode;
  logic [31:0]      imm32;

  logic is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic is_legal, writes_rd;
  logic imem_req_c, dmem_req_c, pc_we_c, rf_we_c;
  logic [1:0] pc_sel_c;

  assign opcode    = ir[6:0];
  assign is_r      = (opcode == OP_R);
  assign is_imm    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_legal  = is_r | is_imm | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;
  assign writes_rd = is_r | is_imm | is_load | is_jal | is_jalr | is_lui | is_auipc;

  assign rs1         = ir[19:15];
  assign rs2         = ir[24:20];
  assign rd          = ir[11:7];
  assign dmem_funct3 = ir[14:12];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir        <= 32'h0000_0013;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_ready)
        ir <= imem_rdata;
      if (pc_we_c)
        retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 2'b00;
    rf_we_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready)
          state_d = S_DECODE;
      end
      S_DECODE: begin
`ifdef CU_ILLEGAL_TRAP_EN
        state_d = is_legal ? S_EXEC : S_TRAP;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we_c  = 1'b1;
          pc_sel_c = branch_taken ? 2'b01 : 2'b00;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          // Unknown opcodes in the non-trapping build fall through here as NOPs.
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we_c  = writes_rd && (ir[11:7] != 5'd0);
        pc_we_c  = 1'b1;
        pc_sel_c = (is_jal || is_jalr) ? 2'b01 : 2'b00;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
`ifdef CU_ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is high since the state register only clears on the edge.
  assign imem_req = imem_req_c & ~reset;
  assign dmem_req = dmem_req_c & ~reset;
  assign dmem_we  = dmem_req_c & is_store & ~reset;
  assign pc_we    = pc_we_c & ~reset;
  assign rf_we    = rf_we_c & ~reset;
  assign pc_sel   = pc_sel_c;
  assign state    = state_q;
  assign retired  = retired_q;

`ifdef CU_ILLEGAL_TRAP_EN
  assign trap = (state_q == S_TRAP) & ~reset;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    alu_a_sel  = 2'b00;
    alu_b_sel  = 1'b0;
    alu_func3  = 3'b000;
    alu_subsra = 1'b0;
    pc_lsb_clr = 1'b0;
    rf_wsel    = 2'b00;
    case (opcode)
      OP_R: begin
        alu_func3  = ir[14:12];
        alu_subsra = ir[30];
      end
      OP_IMM: begin
        alu_b_sel  = 1'b1;
        alu_func3  = ir[14:12];
        alu_subsra = (ir[14:12] == 3'b101) ? ir[30] : 1'b0;
      end
      OP_LOAD: begin
        alu_b_sel = 1'b1;
        rf_wsel   = 2'b01;
      end
      OP_STORE: alu_b_sel = 1'b1;
      OP_BRANCH: begin
        alu_a_sel = 2'b01;
        alu_b_sel = 1'b1;
      end
      OP_JAL: begin
        alu_a_sel = 2'b01;
        alu_b_sel = 1'b1;
        rf_wsel   = 2'b10;
      end
      OP_JALR: begin
        alu_b_sel  = 1'b1;
        pc_lsb_clr = 1'b1;
        rf_wsel    = 2'b10;
      end
      OP_LUI: begin
        alu_a_sel = 2'b10;
        alu_b_sel = 1'b1;
      end
      OP_AUIPC: begin
        alu_a_sel = 2'b01;
        alu_b_sel = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm32 = 32'd0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:                 imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:                imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {ir[31:12], 12'd0};
      OP_JAL:                   imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                  imm32 = 32'd0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed, table-driven bench for cu_multicycle (CNT_W = 4 so the retired counter wraps quickly).
module tb_cu_multicycle;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             imem_req, imem_ready;
  logic [31:0]      imem_rdata;
  logic             dmem_req, dmem_we, dmem_ready;
  logic [2:0]       dmem_funct3;
  logic             branch_taken;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             pc_lsb_clr;
  logic [1:0]       alu_a_sel;
  logic             alu_b_sel;
  logic [2:0]       alu_func3;
  logic             alu_subsra;
  logic             rf_we;
  logic [1:0]       rf_wsel;
  logic [4:0]       rs1, rs2, rd;
  logic [XLEN-1:0]  imm;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic             trap;

  cu_multicycle #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .dmem_funct3(dmem_funct3),
    .branch_taken(branch_taken),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_lsb_clr(pc_lsb_clr),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_func3(alu_func3), .alu_subsra(alu_subsra),
    .rf_we(rf_we), .rf_wsel(rf_wsel),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .state(state), .retired(retired), .trap(trap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int ret_model = 0;

  typedef struct {
    logic [31:0] instr;
    logic        bt;
    int          iw;
    int          dw;
    int          cyc;
    int          rfwe;
    logic [1:0]  wsel;
    logic [1:0]  psel;
    int          dreq;
    int          dwe;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        sub;
    logic [1:0]  asel;
    logic        bsel;
    logic        lsb;
    logic [4:0]  rd;
    logic [31:0] seq;
    int          trapn;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    ret_model = 0;
  endtask

  // Runs one instruction from FETCH until its pc_we strobe; ready inputs are held high
  // (and rdata corrupted) outside their own states to show they are ignored there.
  task automatic run_instr(input logic [31:0] instr, input logic bt, input int iw,
                           input int dw, output vec_t r);
    int  fw;
    int  mw;
    bit  done;
    fw = 0; mw = 0; done = 0;
    r = '{default: '0};
    r.cyc = -1;
    for (int c = 1; c <= 40 && !done; c++) begin
      imem_rdata   = (state == 3'd0) ? instr : ~instr;
      imem_ready   = (state == 3'd0) ? (fw >= iw) : 1'b1;
      dmem_ready   = (state == 3'd3) ? (mw >= dw) : 1'b1;
      branch_taken = (state == 3'd2) ? bt : ~bt;
      #1;
      r.seq = (r.seq << 3) | 32'(state);
      if (state == 3'd0 && !imem_ready) fw++;
      if (state == 3'd3 && !dmem_ready) mw++;
      if (dmem_req) r.dreq++;
      if (dmem_we)  r.dwe++;
      if (rf_we)    r.rfwe++;
      if (trap)     r.trapn++;
      if (state == 3'd2) begin
        r.imm  = imm;
        r.f3   = alu_func3;
        r.sub  = alu_subsra;
        r.asel = alu_a_sel;
        r.bsel = alu_b_sel;
        r.lsb  = pc_lsb_clr;
        r.rd   = rd;
      end
      if (pc_we) begin
        r.cyc  = c;
        r.psel = pc_sel;
        r.wsel = rf_wsel;
        done   = 1;
      end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t e, input vec_t r);
    chk({tag, "_cycles"}, r.cyc,  e.cyc);
    chk({tag, "_rf_we"},  r.rfwe, e.rfwe);
    chk({tag, "_wsel"},   r.wsel, e.wsel);
    chk({tag, "_pc_sel"}, r.psel, e.psel);
    chk({tag, "_dreq"},   r.dreq, e.dreq);
    chk({tag, "_dwe"},    r.dwe,  e.dwe);
    chk({tag, "_imm"},    r.imm,  e.imm);
    chk({tag, "_func3"},  r.f3,   e.f3);
    chk({tag, "_subsra"}, r.sub,  e.sub);
    chk({tag, "_asel"},   r.asel, e.asel);
    chk({tag, "_bsel"},   r.bsel, e.bsel);
    chk({tag, "_lsbclr"}, r.lsb,  e.lsb);
    chk({tag, "_rd"},     r.rd,   e.rd);
    chk({tag, "_states"}, r.seq,  e.seq);
    chk({tag, "_trap"},   r.trapn, e.trapn);
    ret_model = (ret_model + 1) % 16;
    chk({tag, "_retired"}, retired, ret_model);
  endtask

  initial begin
    vec_t r;
    int   cnt;
    int   pcn;

    //           instr         bt  iw dw cyc rfwe wsel   psel   dreq dwe imm           f3    sub  asel   bsel lsb rd     seq       trapn
    vecs[0]  = '{32'h002081B3, 0,  0, 0, 4,  1,   2'b00, 2'b00, 0,   0,  32'h0,        3'd0, 0,   2'b00, 0,   0,  5'd3,  32'h054,    0};
    vecs[1]  = '{32'h002081B3, 0,  2, 0, 6,  1,   2'b00, 2'b00, 0,   0,  32'h0,        3'd0, 0,   2'b00, 0,   0,  5'd3,  32'h054,    0};
    vecs[2]  = '{32'h40208233, 0,  0, 0, 4,  1,   2'b00, 2'b00, 0,   0,  32'h0,        3'd0, 1,   2'b00, 0,   0,  5'd4,  32'h054,    0};
    vecs[3]  = '{32'h0080A283, 0,  0, 3, 8,  1,   2'b01, 2'b00, 4,   0,  32'h8,        3'd0, 0,   2'b00, 1,   0,  5'd5,  32'h536DC,  0};
    vecs[4]  = '{32'h00208463, 1,  0, 0, 3,  0,   2'b00, 2'b01, 0,   0,  32'h8,        3'd0, 0,   2'b01, 1,   0,  5'd8,  32'h00A,    0};
    vecs[5]  = '{32'h00208463, 0,  0, 0, 3,  0,   2'b00, 2'b00, 0,   0,  32'h8,        3'd0, 0,   2'b01, 1,   0,  5'd8,  32'h00A,    0};
    vecs[6]  = '{32'h0020A223, 0,  0, 0, 4,  0,   2'b00, 2'b00, 1,   1,  32'h4,        3'd0, 0,   2'b00, 1,   0,  5'd4,  32'h053,    0};
    vecs[7]  = '{32'h4030D313, 0,  0, 0, 4,  1,   2'b00, 2'b00, 0,   0,  32'h403,      3'd5, 1,   2'b00, 1,   0,  5'd6,  32'h054,    0};
    vecs[8]  = '{32'hFFF08393, 0,  0, 0, 4,  1,   2'b00, 2'b00, 0,   0,  32'hFFFFFFFF, 3'd0, 0,   2'b00, 1,   0,  5'd7,  32'h054,    0};
    vecs[9]  = '{32'h00000013, 0,  0, 0, 4,  0,   2'b00, 2'b00, 0,   0,  32'h0,        3'd0, 0,   2'b00, 1,   0,  5'd0,  32'h054,    0};
    vecs[10] = '{32'h12345437, 0,  0, 0, 4,  1,   2'b00, 2'b00, 0,   0,  32'h12345000, 3'd0, 0,   2'b10, 1,   0,  5'd8,  32'h054,    0};
    vecs[11] = '{32'h00001497, 0,  0, 0, 4,  1,   2'b00, 2'b00, 0,   0,  32'h1000,     3'd0, 0,   2'b01, 1,   0,  5'd9,  32'h054,    0};
    vecs[12] = '{32'h010000EF, 0,  0, 0, 4,  1,   2'b10, 2'b01, 0,   0,  32'h10,       3'd0, 0,   2'b01, 1,   0,  5'd1,  32'h054,    0};
    vecs[13] = '{32'h00008067, 0,  0, 0, 4,  0,   2'b10, 2'b01, 0,   0,  32'h0,        3'd0, 0,   2'b00, 1,   1,  5'd0,  32'h054,    0};
    vecs[14] = '{32'h0080A283, 0,  0, 0, 5,  1,   2'b01, 2'b00, 1,   0,  32'h8,        3'd0, 0,   2'b00, 1,   0,  5'd5,  32'h29C,    0};

    reset = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    imem_rdata = 32'h002081B3;
    branch_taken = 1'b0;

    // Strobes stay low for the whole reset window even with both readies high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_strobes", {imem_req, dmem_req, pc_we, rf_we, trap}, 5'b0);
    end
    chk("reset_state", state, 3'd0);
    chk("reset_retired", retired, 0);
    reset = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("first_imem_req", imem_req, 1'b1);
    @(negedge clk);
    chk("fetch_hold_req", {state, imem_req}, {3'd0, 1'b1});

    for (int i = 0; i < NV; i++) begin
      run_instr(vecs[i].instr, vecs[i].bt, vecs[i].iw, vecs[i].dw, r);
      check_vec($sformatf("v%0d", i), vecs[i], r);
    end

`ifdef CU_ILLEGAL_TRAP_EN
    cnt = 0;
    pcn = 0;
    for (int c = 1; c <= 22; c++) begin
      imem_rdata = 32'h0000007F;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      #1;
      if (c == 3) chk("trap_cycle3", trap, 1'b1);
      if (c >= 3 && trap && !imem_req && !dmem_req && !rf_we) cnt++;
      if (pc_we) pcn++;
      @(negedge clk);
    end
    chk("trap_hold20", cnt, 20);
    chk("trap_no_pc_we", pcn, 0);
    chk("trap_state", state, 3'd5);
    chk("trap_retired", retired, ret_model);
    do_reset(1);
    chk("trap_cleared", {trap, state}, {1'b0, 3'd0});
`else
    run_instr(32'h0000007F, 1'b0, 0, 0, r);
    chk("illegal_cycles", r.cyc, 4);
    chk("illegal_rf_we", r.rfwe, 0);
    chk("illegal_pc_sel", r.psel, 2'b00);
    chk("illegal_trap", r.trapn, 0);
    ret_model = (ret_model + 1) % 16;
    chk("illegal_retired", retired, ret_model);
`endif

    // Counter wrap with a 4-bit retired counter.
    do_reset(2);
    chk("wrap_start", retired, 0);
    for (int i = 0; i < 15; i++) run_instr(32'h00000013, 1'b0, 0, 0, r);
    chk("wrap_at15", retired, 15);
    run_instr(32'h00000013, 1'b0, 0, 0, r);
    chk("wrap_to0", retired, 0);
    run_instr(32'h00000013, 1'b0, 0, 0, r);
    chk("wrap_then1", retired, 1);

    // Reset while a store sits in MEM waiting on dmem_ready.
    imem_rdata = 32'h0020A223;
    dmem_ready = 1'b0;
    for (int c = 0; c < 10 && state != 3'd3; c++) begin
      imem_ready = (state == 3'd0);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    chk("mid_mem_reached", state, 3'd3);
    @(negedge clk);
    chk("mid_mem_req", dmem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", state, 3'd0);
    chk("mid_rst_dreq", dmem_req, 1'b0);
    chk("mid_rst_retired", retired, 0);
    reset = 1'b0;
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("late_ready_state", state, 3'd0);
    chk("late_ready_strobes", {dmem_req, pc_we, retired}, {1'b0, 1'b0, 4'd0});
    dmem_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
